// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds renamed ALU/branch/jump ops until both
// operands resolve via ALU/LSB broadcast snoop, then dispatches one per cycle.
module reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        issue_en,
  input  logic [3:0]  issue_rob_pos,
  input  logic [6:0]  issue_opcode,
  input  logic [2:0]  issue_funct3,
  input  logic        issue_funct7,
  input  logic [31:0] issue_rs1_val,
  input  logic [4:0]  issue_rs1_rob_id,
  input  logic [31:0] issue_rs2_val,
  input  logic [4:0]  issue_rs2_rob_id,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_pc,
  output logic        rs_nxt_full,
  output logic        alu_en,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic        alu_funct7,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_pc,
  output logic [3:0]  alu_rob_pos,
  input  logic        alu_result,
  input  logic [3:0]  alu_result_rob_pos,
  input  logic [31:0] alu_result_val,
  input  logic        lsb_result,
  input  logic [3:0]  lsb_result_rob_pos,
  input  logic [31:0] lsb_result_val
);
  logic [RS_SIZE-1:0] r_busy;
  logic [6:0]  r_op   [RS_SIZE];
  logic [2:0]  r_f3   [RS_SIZE];
  logic        r_f7   [RS_SIZE];
  logic [31:0] r_val1 [RS_SIZE];
  logic [4:0]  r_q1   [RS_SIZE];
  logic [31:0] r_val2 [RS_SIZE];
  logic [4:0]  r_q2   [RS_SIZE];
  logic [31:0] r_imm  [RS_SIZE];
  logic [31:0] r_pc   [RS_SIZE];
  logic [3:0]  r_rob  [RS_SIZE];

  logic                w_sel_vld, w_free_vld, w_disp;
  logic [RS_IDX_W-1:0] w_sel_idx, w_free_idx;
  logic [RS_IDX_W:0]   w_cnt;
  logic [RS_IDX_W+1:0] w_nxt_cnt;
  logic [36:0]         w_snp1 [RS_SIZE];
  logic [36:0]         w_snp2 [RS_SIZE];
  logic [36:0]         w_in1, w_in2;

  // Returns {q, val}; ALU broadcast has priority over LSB on the same tag.
  function automatic logic [36:0] snoop(
    input logic [4:0] q, input logic [31:0] v,
    input logic ae, input logic [3:0] ap, input logic [31:0] av,
    input logic le, input logic [3:0] lp, input logic [31:0] lv);
    if (q[4] && ae && ap == q[3:0]) return {5'b0, av};
    if (q[4] && le && lp == q[3:0]) return {5'b0, lv};
    return {q, v};
  endfunction

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_idx  = '0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    w_cnt      = '0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      if (r_busy[i] && !r_q1[i][4] && !r_q2[i][4]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = RS_IDX_W'(i);
      end
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = RS_IDX_W'(i);
      end
      w_cnt = w_cnt + {{RS_IDX_W{1'b0}}, r_busy[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_snp1[i] = snoop(r_q1[i], r_val1[i], alu_result, alu_result_rob_pos, alu_result_val,
                        lsb_result, lsb_result_rob_pos, lsb_result_val);
      w_snp2[i] = snoop(r_q2[i], r_val2[i], alu_result, alu_result_rob_pos, alu_result_val,
                        lsb_result, lsb_result_rob_pos, lsb_result_val);
    end
  end

  assign w_in1 = snoop(issue_rs1_rob_id, issue_rs1_val, alu_result, alu_result_rob_pos,
                       alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val);
  assign w_in2 = snoop(issue_rs2_rob_id, issue_rs2_val, alu_result, alu_result_rob_pos,
                       alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val);

  assign w_disp      = w_sel_vld & rdy & ~rollback;
  assign w_nxt_cnt   = {1'b0, w_cnt} + {{(RS_IDX_W+1){1'b0}}, issue_en}
                     - {{(RS_IDX_W+1){1'b0}}, w_disp};
  assign rs_nxt_full = (w_nxt_cnt == (RS_IDX_W+2)'(RS_SIZE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]   <= '0;
        r_f3[i]   <= '0;
        r_f7[i]   <= 1'b0;
        r_val1[i] <= '0;
        r_q1[i]   <= '0;
        r_val2[i] <= '0;
        r_q2[i]   <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_rob[i]  <= '0;
      end
    end else if (rollback) begin
      r_busy <= '0;
      alu_en <= 1'b0;
    end else if (!rdy) begin
      alu_en <= 1'b0;
    end else begin
      alu_en <= w_sel_vld;
      if (w_sel_vld) begin
        alu_opcode        <= r_op[w_sel_idx];
        alu_funct3        <= r_f3[w_sel_idx];
        alu_funct7        <= r_f7[w_sel_idx];
        alu_val1          <= r_val1[w_sel_idx];
        alu_val2          <= r_val2[w_sel_idx];
        alu_imm           <= r_imm[w_sel_idx];
        alu_pc            <= r_pc[w_sel_idx];
        alu_rob_pos       <= r_rob[w_sel_idx];
        r_busy[w_sel_idx] <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          {r_q1[i], r_val1[i]} <= w_snp1[i];
          {r_q2[i], r_val2[i]} <= w_snp2[i];
        end
      end
      // Free slot comes from registered state, so a slot dispatched now is not refilled now.
      if (issue_en && w_free_vld) begin
        r_busy[w_free_idx]                   <= 1'b1;
        r_op[w_free_idx]                     <= issue_opcode;
        r_f3[w_free_idx]                     <= issue_funct3;
        r_f7[w_free_idx]                     <= issue_funct7;
        r_imm[w_free_idx]                    <= issue_imm;
        r_pc[w_free_idx]                     <= issue_pc;
        r_rob[w_free_idx]                    <= issue_rob_pos;
        {r_q1[w_free_idx], r_val1[w_free_idx]} <= w_in1;
        {r_q2[w_free_idx], r_val2[w_free_idx]} <= w_in2;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic,
// checked against a slot-array reference model of the station.
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue_en;
  logic [3:0]  issue_rob_pos;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [4:0]  issue_rs1_rob_id, issue_rs2_rob_id;
  logic        rs_nxt_full, alu_en, alu_funct7;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue_en(issue_en),
    .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_rs1_val(issue_rs1_val),
    .issue_rs1_rob_id(issue_rs1_rob_id), .issue_rs2_val(issue_rs2_val),
    .issue_rs2_rob_id(issue_rs2_rob_id), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .rs_nxt_full(rs_nxt_full), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_val1(alu_val1),
    .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val), .lsb_result(lsb_result),
    .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val)
  );

  logic [143:0] act;
  assign act = {alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
                alu_imm, alu_pc, alu_rob_pos};

  // Reference model: slot array; a tag of -1 means the operand value is known.
  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2, imm, pc;
    int          t1, t2;
    logic [3:0]  rob;
  } ent_t;
  ent_t m[16];
  logic        e_en, e_f7;
  logic [6:0]  e_op;
  logic [2:0]  e_f3;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;

  function automatic logic [143:0] exp_vec();
    return {e_en, e_op, e_f3, e_f7, e_v1, e_v2, e_imm, e_pc, e_rob};
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i].busy) n++;
    return n;
  endfunction

  function automatic int m_ready();
    for (int i = 0; i < 16; i++) if (m[i].busy && m[i].t1 < 0 && m[i].t2 < 0) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic bit m_full();
    int n = m_count();
    if (issue_en) n++;
    if (rdy && !rollback && m_ready() >= 0) n--;
    return n == 16;
  endfunction

  function automatic logic [31:0] snp_v(int t, logic [31:0] v);
    if (t >= 0 && alu_result && int'(alu_result_rob_pos) == t) return alu_result_val;
    if (t >= 0 && lsb_result && int'(lsb_result_rob_pos) == t) return lsb_result_val;
    return v;
  endfunction

  function automatic int snp_t(int t);
    if (t >= 0 && alu_result && int'(alu_result_rob_pos) == t) return -1;
    if (t >= 0 && lsb_result && int'(lsb_result_rob_pos) == t) return -1;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i].busy = 0;
    {e_en, e_op, e_f3, e_f7, e_v1, e_v2, e_imm, e_pc, e_rob} = '0;
  endtask

  task automatic model_edge();
    int d, f;
    if (rollback) begin
      for (int i = 0; i < 16; i++) m[i].busy = 0;
      e_en = 0;
    end else if (!rdy) begin
      e_en = 0;
    end else begin
      d = m_ready();
      f = m_free();
      for (int i = 0; i < 16; i++) begin
        if (m[i].busy && i != d) begin
          m[i].v1 = snp_v(m[i].t1, m[i].v1); m[i].t1 = snp_t(m[i].t1);
          m[i].v2 = snp_v(m[i].t2, m[i].v2); m[i].t2 = snp_t(m[i].t2);
        end
      end
      e_en = (d >= 0);
      if (d >= 0) begin
        e_op = m[d].op; e_f3 = m[d].f3; e_f7 = m[d].f7; e_v1 = m[d].v1; e_v2 = m[d].v2;
        e_imm = m[d].imm; e_pc = m[d].pc; e_rob = m[d].rob;
        m[d].busy = 0;
      end
      if (issue_en) begin
        checks++;
        if (f < 0) begin
          $display("FAIL issue_overflow: issue_en with free=0, required free>0");
          errs++;
        end else begin
          m[f].busy = 1; m[f].op = issue_opcode; m[f].f3 = issue_funct3;
          m[f].f7 = issue_funct7; m[f].imm = issue_imm; m[f].pc = issue_pc;
          m[f].rob = issue_rob_pos;
          m[f].t1 = issue_rs1_rob_id[4] ? int'(issue_rs1_rob_id[3:0]) : -1;
          m[f].t2 = issue_rs2_rob_id[4] ? int'(issue_rs2_rob_id[3:0]) : -1;
          m[f].v1 = snp_v(m[f].t1, issue_rs1_val); m[f].t1 = snp_t(m[f].t1);
          m[f].v2 = snp_v(m[f].t2, issue_rs2_val); m[f].t2 = snp_t(m[f].t2);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1; rollback = 0; issue_en = 0;
    alu_result = 0; lsb_result = 0;
  endtask

  task automatic set_issue(input logic [6:0] op, input logic [31:0] v1, input logic [4:0] q1,
                           input logic [31:0] v2, input logic [4:0] q2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [3:0] rob);
    issue_en = 1; issue_opcode = op; issue_funct3 = 3'd0; issue_funct7 = 1'b0;
    issue_rs1_val = v1; issue_rs1_rob_id = q1; issue_rs2_val = v2; issue_rs2_rob_id = q2;
    issue_imm = imm; issue_pc = pc; issue_rob_pos = rob;
  endtask

  task automatic test_reset();
    idle();
    issue_rob_pos = 0; issue_opcode = 0; issue_funct3 = 0; issue_funct7 = 0;
    issue_rs1_val = 0; issue_rs1_rob_id = 0; issue_rs2_val = 0; issue_rs2_rob_id = 0;
    issue_imm = 0; issue_pc = 0; alu_result_rob_pos = 0; alu_result_val = 0;
    lsb_result_rob_pos = 0; lsb_result_val = 0;
    rst = 1; #1 rst = 0; #6;
    checks++;
    if (act !== 144'd0 || rs_nxt_full !== 1'b0) begin
      $display("FAIL reset: act=%h full=%b required all 0", act, rs_nxt_full); errs++;
    end
    @(negedge clk); rst = 1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act !== 144'd0 || rs_nxt_full !== 1'b0) begin
        $display("FAIL reset_idle%0d: act=%h full=%b required all 0", i, act, rs_nxt_full);
        errs++;
      end
    end
  endtask

  task automatic test_addi();
    set_issue(7'b0010011, 32'd5, 5'd0, 32'd0, 5'd0, 32'd7, 32'h100, 4'd2);
    tick(); idle();
    checks++;
    if (alu_en !== 1'b0) begin $display("FAIL addi_lat: alu_en=%b required 0", alu_en); errs++; end
    tick();
    checks++;
    if (alu_en !== 1'b1 || alu_val1 !== 32'd5 || alu_imm !== 32'd7 || alu_rob_pos !== 4'd2 ||
        act !== exp_vec()) begin
      $display("FAIL addi_disp: act=%h required %h", act, exp_vec()); errs++;
    end
    tick();
    checks++;
    if (alu_en !== 1'b0) begin $display("FAIL addi_pulse: alu_en=%b required 0", alu_en); errs++; end
  endtask

  task automatic test_wakeup();
    set_issue(7'b0110011, 32'hDEAD, 5'b1_0011, 32'd1, 5'd0, 32'd0, 32'h200, 4'd6);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin alu_result = 1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h10; end
      tick(); idle();
      checks++;
      if (alu_en !== 1'b0) begin
        $display("FAIL wake_early%0d: alu_en=%b required 0", i, alu_en); errs++;
      end
    end
    tick();
    checks++;
    if (alu_en !== 1'b1 || alu_val1 !== 32'h10 || alu_val2 !== 32'd1 || act !== exp_vec()) begin
      $display("FAIL wake_disp: act=%h required %h", act, exp_vec()); errs++;
    end
  endtask

  task automatic test_dual_snoop();
    set_issue(7'b0110011, 32'h0, 5'b1_0100, 32'h0, 5'b1_0101, 32'd0, 32'h300, 4'd8);
    lsb_result = 1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'hAA;
    alu_result = 1; alu_result_rob_pos = 4'd5; alu_result_val = 32'hBB;
    tick(); idle();
    checks++;
    if (alu_en !== 1'b0) begin $display("FAIL dual_lat: alu_en=%b required 0", alu_en); errs++; end
    tick();
    checks++;
    if (alu_en !== 1'b1 || alu_val1 !== 32'hAA || alu_val2 !== 32'hBB || act !== exp_vec()) begin
      $display("FAIL dual_disp: act=%h required %h", act, exp_vec()); errs++;
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_issue(7'b1100011, 32'h0, 5'b1_0111, 32'd3, 5'd0, 32'd0, 32'(i * 4), 4'(i));
      #1;
      checks++;
      if (rs_nxt_full !== (i == 15) || rs_nxt_full !== m_full()) begin
        $display("FAIL full_issue%0d: full=%b required %b", i, rs_nxt_full, i == 15); errs++;
      end
      tick();
    end
    idle();
    alu_result = 1; alu_result_rob_pos = 4'd7; alu_result_val = 32'h77;
    #1;
    checks++;
    if (rs_nxt_full !== 1'b1) begin $display("FAIL full_hold: full=%b required 1", rs_nxt_full); errs++; end
    tick(); idle();
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (rs_nxt_full !== m_full() || rs_nxt_full !== 1'b0) begin
        $display("FAIL full_drain%0d: full=%b required 0", k, rs_nxt_full); errs++;
      end
      tick();
      checks++;
      if (alu_en !== 1'b1 || alu_pc !== 32'(k * 4) || alu_val1 !== 32'h77 || act !== exp_vec()) begin
        $display("FAIL full_order%0d: act=%h required %h", k, act, exp_vec()); errs++;
      end
    end
    tick();
    checks++;
    if (alu_en !== 1'b0) begin $display("FAIL full_empty: alu_en=%b required 0", alu_en); errs++; end
  endtask

  task automatic test_rollback();
    for (int i = 0; i < 4; i++) begin
      set_issue(7'b0110011, 32'h0, 5'(16 + 8 + i), 32'h0, 5'd0, 32'd0, 32'h400 + 32'(i), 4'(i));
      tick();
    end
    set_issue(7'b0010011, 32'h55, 5'd0, 32'h0, 5'd0, 32'd1, 32'h500, 4'd12);
    tick(); idle(); rdy = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (alu_en !== 1'b0) begin $display("FAIL rdy_hold%0d: alu_en=%b required 0", i, alu_en); errs++; end
    end
    rdy = 1;
    tick();
    checks++;
    if (alu_en !== 1'b1 || alu_pc !== 32'h500 || act !== exp_vec()) begin
      $display("FAIL rdy_release: act=%h required %h", act, exp_vec()); errs++;
    end
    set_issue(7'b0010011, 32'h66, 5'd0, 32'h0, 5'd0, 32'd2, 32'h600, 4'd13);
    tick(); idle();
    rollback = 1;
    set_issue(7'b0010011, 32'h77, 5'd0, 32'h0, 5'd0, 32'd3, 32'h700, 4'd14);
    tick(); idle();
    #1;
    checks++;
    if (alu_en !== 1'b0 || rs_nxt_full !== 1'b0) begin
      $display("FAIL rollback_edge: alu_en=%b full=%b required 0 0", alu_en, rs_nxt_full); errs++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        alu_result = 1; alu_result_rob_pos = 4'(8 + 2 * i); alu_result_val = 32'h1;
        lsb_result = 1; lsb_result_rob_pos = 4'(9 + 2 * i); lsb_result_val = 32'h2;
      end
      tick(); idle();
      checks++;
      if (alu_en !== 1'b0 || act !== exp_vec()) begin
        $display("FAIL rollback_stale%0d: act=%h required %h", i, act, exp_vec()); errs++;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [4];
    ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b1100011; ops[3] = 7'b1101111;
    for (int c = 0; c < 600; c++) begin
      rdy      = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 59) == 0);
      issue_en = ($urandom_range(0, 1) == 1) && (m_count() < 16);
      issue_opcode = ops[$urandom_range(0, 3)];
      issue_funct3 = 3'($urandom); issue_funct7 = 1'($urandom);
      issue_rs1_val = $urandom; issue_rs2_val = $urandom;
      issue_rs1_rob_id = {1'($urandom_range(0, 1)), 4'($urandom)};
      issue_rs2_rob_id = {1'($urandom_range(0, 1)), 4'($urandom)};
      issue_imm = $urandom; issue_pc = $urandom; issue_rob_pos = 4'($urandom);
      alu_result = ($urandom_range(0, 2) == 0);
      alu_result_rob_pos = 4'($urandom); alu_result_val = $urandom;
      lsb_result = ($urandom_range(0, 2) == 0);
      lsb_result_rob_pos = 4'($urandom); lsb_result_val = $urandom;
      if (alu_result && lsb_result && lsb_result_rob_pos == alu_result_rob_pos)
        lsb_result_rob_pos = alu_result_rob_pos + 4'd1;
      #1;
      checks++;
      if (rs_nxt_full !== m_full()) begin
        $display("FAIL rand_full%0d: full=%b required %b", c, rs_nxt_full, m_full()); errs++;
      end
      tick();
      checks++;
      if (act !== exp_vec()) begin
        $display("FAIL rand_disp%0d: act=%h required %h", c, act, exp_vec()); errs++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wakeup();
    test_dual_snoop();
    test_full();
    test_rollback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
